seq_div: RTL and testbench

- Sequential restoring divider: the inverse of the team's shift-and-add multiply-accumulate block.
- Computes an unsigned N-bit quotient and remainder, one quotient bit per clock, MSB first.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic demos; the pair is used for round-trip checks (P = A*B, then P/B -> A).

---
 rtl/seq_div_pkg.sv | 17 +
 rtl/seq_div_step.sv | 24 ++
 rtl/seq_div.sv | 127 ++++++++++++
 tb/tb_seq_div.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Supports operand widths up to MAX_N bits.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ZERO = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int unsigned MAX_N = 64;

   // Quotient reported for a divide by zero; sliced to N bits at the use site.
   localparam logic [MAX_N-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// The compare runs at N+1 bits so it never overflows.
module div_step #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] rem_i,
   input  logic         msb_i,
   input  logic [N-1:0] dvs_i,
   output logic [N-1:0] rem_o,
   output logic         q_o
);

   logic [N:0]   t;
   logic [N-1:0] diff;

   always_comb begin
      t     = {rem_i, msb_i};
      // Whenever the subtract is taken the true difference is below 2^N, so N bits hold it.
      diff  = t[N-1:0] - dvs_i;
      q_o   = (t >= {1'b0, dvs_i});
      rem_o = q_o ? diff : t[N-1:0];
   end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: unsigned N-bit quotient/remainder, one quotient bit per clock,
// MSB first, with a start/busy/done handshake.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output state_e       dbg_state_o
);

   localparam int unsigned CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

   state_e state_q, state_d;

   logic [N-1:0]  dvd_q, dvs_q, rem_q, quo_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  q_q, r_q;
   logic          dbz_q;

   logic          load, step, finish_run, finish_zero;
   logic [N-1:0]  rem_d, quo_d;
   logic          qbit;

   div_step #(.N(N)) u_step (
      .rem_i (rem_q),
      .msb_i (dvd_q[N-1]),
      .dvs_i (dvs_q),
      .rem_o (rem_d),
      .q_o   (qbit)
   );

   assign quo_d = {quo_q[N-2:0], qbit};

   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      step        = 1'b0;
      finish_run  = 1'b0;
      finish_zero = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new start so back-to-back ops take N+1 cycles.
            if (start) begin
               load    = 1'b1;
               state_d = (B == '0) ? ZERO : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == LAST_ITER) begin
               finish_run = 1'b1;
               state_d    = DONE;
            end
         end
         ZERO: begin
            finish_zero = 1'b1;
            state_d     = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         q_q   <= '0;
         r_q   <= '0;
         dbz_q <= 1'b0;
      end else begin
         if (load) begin
            dvd_q <= A;
            dvs_q <= B;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
         end else if (step) begin
            dvd_q <= {dvd_q[N-2:0], 1'b0};
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
         end
         // Results move only on the completion edge, never showing partial values.
         if (finish_run) begin
            q_q   <= quo_d;
            r_q   <= rem_d;
            dbz_q <= 1'b0;
         end else if (finish_zero) begin
            q_q   <= DBZ_QUOTIENT[N-1:0];
            r_q   <= dvd_q;
            dbz_q <= 1'b1;
         end
      end
   end

   assign Q           = q_q;
   assign R           = r_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == RUN) || (state_q == ZERO);
   assign done        = (state_q == DONE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div (N=4): a transaction-level model predicts busy/done/Q/R/div_by_zero
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_seq_div;
   import seq_div_pkg::*;

   localparam int N = 4;
   localparam int W = 2 * N + 1;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a     = '0;
   logic [N-1:0] b     = '0;
   logic [N-1:0] q, r;
   logic         busy, done, dbz;
   state_e       dbg_state;

   seq_div #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .A           (a),
      .B           (b),
      .Q           (q),
      .R           (r),
      .busy        (busy),
      .done        (done),
      .div_by_zero (dbz),
      .dbg_state_o (dbg_state)
   );

   // clock/reset block
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // Reference model: an accepted op is queued with its arithmetic result and
   // retires N cycles later (1 cycle for B==0), pulsing done for one cycle.
   logic [W-1:0] exp_q[$];
   int           m_left = 0;
   logic [N-1:0] m_q = '0, m_r = '0;
   logic         m_dbz = 1'b0, m_done = 1'b0;
   logic [N-1:0] all_ones = '1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_q    = '0;
         m_r    = '0;
         m_dbz  = 1'b0;
         m_done = 1'b0;
         exp_q.delete();
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               {m_dbz, m_q, m_r} = exp_q.pop_front();
               m_done = 1'b1;
            end
         end else if (start) begin
            if (b == '0) begin
               exp_q.push_back({1'b1, all_ones, a});
               m_left = 1;
            end else begin
               exp_q.push_back({1'b0, a / b, a % b});
               m_left = N;
            end
         end
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("done", int'(done), int'(m_done));
      chk("Q", int'(q), int'(m_q));
      chk("R", int'(r), int'(m_r));
      chk("div_by_zero", int'(dbz), int'(m_dbz));
      chk("busy_done_overlap", int'(busy && done), 0);
   end

   // driver tasks
   task automatic wait_idle();
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic do_op(input logic [N-1:0] ai, input logic [N-1:0] bi);
      int lat;
      bit got;
      wait_idle();
      start = 1'b1;
      a     = ai;
      b     = bi;
      @(negedge clk);
      start = 1'b0;
      a     = N'($urandom_range(0, 15));
      b     = N'($urandom_range(0, 15));
      lat   = 1;
      got   = done;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         got = done;
      end
      chk("done_seen", int'(got), 1);
      chk("latency", lat, (bi == '0) ? 2 : N + 1);
   endtask

   initial begin
      int cnt;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_Q", int'(q), 0);
      chk("reset_R", int'(r), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_dbz", int'(dbz), 0);
      rst_n = 1'b1;

      do_op(4'd13, 4'd3);
      chk("lit_13_3_Q", int'(q), 4);
      chk("lit_13_3_R", int'(r), 1);
      chk("lit_13_3_dbz", int'(dbz), 0);

      do_op(4'd7, 4'd0);
      chk("lit_7_0_Q", int'(q), 15);
      chk("lit_7_0_R", int'(r), 7);
      chk("lit_7_0_dbz", int'(dbz), 1);
      do_op(4'd9, 4'd2);
      chk("lit_9_2_Q", int'(q), 4);
      chk("lit_9_2_R", int'(r), 1);
      chk("lit_9_2_dbz", int'(dbz), 0);

      do_op(4'd3, 4'd9);
      chk("lit_3_9_Q", int'(q), 0);
      chk("lit_3_9_R", int'(r), 3);

      // start pulsed during busy must be ignored
      wait_idle();
      start = 1'b1; a = 4'd15; b = 4'd1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 4'd8; b = 4'd8;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (!done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("lit_15_1_Q", int'(q), 15);
      chk("lit_15_1_R", int'(r), 0);
      repeat (3) @(negedge clk);
      chk("ignored_start_busy", int'(busy), 0);
      chk("ignored_start_Q", int'(q), 15);

      // asynchronous reset in the middle of a run
      wait_idle();
      start = 1'b1; a = 4'd12; b = 4'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_Q", int'(q), 0);
      chk("midreset_R", int'(r), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_dbz", int'(dbz), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) cnt++;
      end
      chk("no_done_after_reset", cnt, 0);
      do_op(4'd12, 4'd5);
      chk("lit_12_5_Q", int'(q), 2);
      chk("lit_12_5_R", int'(r), 2);

      // start held high: accepted in DONE, one result every N+1 cycles
      wait_idle();
      start = 1'b1; a = 4'd11; b = 4'd2;
      cnt = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      start = 1'b0;
      chk("held_done_pulses", cnt, 5);
      chk("held_Q", int'(q), 5);
      chk("held_R", int'(r), 1);

      // exhaustive sweep, B != 0
      for (int ai = 0; ai < 16; ai++)
         for (int bi = 1; bi < 16; bi++)
            do_op(N'(ai), N'(bi));

      // round trip with a product that fits in N bits
      for (int ai = 0; ai < 16; ai++)
         for (int bi = 1; bi < 16; bi++)
            if (ai * bi < 16) begin
               do_op(N'(ai * bi), N'(bi));
               chk("roundtrip_Q", int'(q), ai);
               chk("roundtrip_R", int'(r), 0);
            end

      // random ops, divide by zero included
      repeat (120) begin
         logic [N-1:0] ra, rb;
         ra = N'($urandom_range(0, 15));
         rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 15));
         do_op(ra, rb);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
